// File: rtl/gpr_writeback_arbiter.sv
// Writeback arbiter for the GPR file: pipeline port A has priority, the multicycle port B
// gets a starvation guarantee. Optional pending-write scoreboard behind GPR_WB_SCOREBOARD_EN.
module gpr_writeback_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        aValid,
    output logic        aReady,
    input  logic [4:0]  aReg,
    input  logic [31:0] aData,
    input  logic        bValid,
    output logic        bReady,
    input  logic [4:0]  bReg,
    input  logic [31:0] bData,
    input  logic        issueValid,
    input  logic [4:0]  issueReg,
    input  logic [4:0]  queryReg1,
    input  logic [4:0]  queryReg2,
    output logic        queryBusy1,
    output logic        queryBusy2,
    output logic        gprWriteEnabled,
    output logic [4:0]  gprWriteRegister,
    output logic [31:0] gprWriteInput
);

    localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]  r_starve;
    logic        r_we;
    logic [4:0]  r_wreg;
    logic [31:0] r_wdata;

    logic w_starved;
    logic w_a_xfer;
    logic w_b_xfer;

    // Handshake: a transfer happens on the rising edge where valid and ready are both high.
    assign w_starved = (r_starve == LP_LIMIT);
    assign bReady    = !aValid || w_starved;
    assign aReady    = !(bValid && w_starved);
    assign w_a_xfer  = aValid && aReady;
    assign w_b_xfer  = bValid && bReady;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_starve <= 4'd0;
        end else if (!bValid || w_b_xfer) begin
            r_starve <= 4'd0;
        end else if (!w_starved) begin
            r_starve <= r_starve + 4'd1;
        end
    end

    // Writes to r0 complete the handshake but never reach the register file.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_we    <= 1'b0;
            r_wreg  <= 5'd0;
            r_wdata <= 32'd0;
        end else if (w_a_xfer && aReg != 5'd0) begin
            r_we    <= 1'b1;
            r_wreg  <= aReg;
            r_wdata <= aData;
        end else if (w_b_xfer && bReg != 5'd0) begin
            r_we    <= 1'b1;
            r_wreg  <= bReg;
            r_wdata <= bData;
        end else begin
            r_we    <= 1'b0;
        end
    end

    assign gprWriteEnabled  = r_we;
    assign gprWriteRegister = r_wreg;
    assign gprWriteInput    = r_wdata;

`ifdef GPR_WB_SCOREBOARD_EN
    logic [31:1] r_busy;
    logic [31:1] w_set;
    logic [31:1] w_clr;
    logic [31:0] w_busy_full;

    always_comb begin
        w_set = '0;
        w_clr = '0;
        for (int i = 1; i < 32; i++) begin
            w_set[i] = issueValid && (issueReg == 5'(i));
            w_clr[i] = w_b_xfer && (bReg == 5'(i));
        end
    end

    // Set is applied after clear so a same-edge issue keeps the register pending.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr) | w_set;
        end
    end

    assign w_busy_full = {r_busy, 1'b0};
    assign queryBusy1  = w_busy_full[queryReg1];
    assign queryBusy2  = w_busy_full[queryReg2];
`else
    logic w_unused_sb;
    assign w_unused_sb = ^{issueValid, issueReg, queryReg1, queryReg2};
    assign queryBusy1  = 1'b0;
    assign queryBusy2  = 1'b0;
`endif

endmodule

// File: tb/tb_gpr_writeback_arbiter.sv
// Bench for gpr_writeback_arbiter: behavioural model with per-cycle compare, directed
// literal checks and a randomized phase. Honours GPR_WB_SCOREBOARD_EN when defined.
module tb_gpr_writeback_arbiter;

    localparam int LIM = 4;

    logic        clk;
    logic        reset;
    logic        aValid, bValid, issueValid;
    logic        aReady, bReady, queryBusy1, queryBusy2;
    logic [4:0]  aReg, bReg, issueReg, queryReg1, queryReg2;
    logic [31:0] aData, bData;
    logic        gprWriteEnabled;
    logic [4:0]  gprWriteRegister;
    logic [31:0] gprWriteInput;

    int n_checks = 0;
    int n_fail   = 0;

    gpr_writeback_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clock(clk), .reset(reset),
        .aValid(aValid), .aReady(aReady), .aReg(aReg), .aData(aData),
        .bValid(bValid), .bReady(bReady), .bReg(bReg), .bData(bData),
        .issueValid(issueValid), .issueReg(issueReg),
        .queryReg1(queryReg1), .queryReg2(queryReg2),
        .queryBusy1(queryBusy1), .queryBusy2(queryBusy2),
        .gprWriteEnabled(gprWriteEnabled), .gprWriteRegister(gprWriteRegister),
        .gprWriteInput(gprWriteInput)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef GPR_WB_SCOREBOARD_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    // behavioural model: cycles B has waited, pending set, last write
    int          m_wait;
    logic [31:0] m_busy;
    logic        m_we;
    logic [4:0]  m_wreg;
    logic [31:0] m_wdata;
    logic        m_last_a_x, m_last_b_x;

    function automatic logic exp_b_ready();
        return !aValid || (m_wait >= LIM);
    endfunction

    function automatic logic exp_a_ready();
        return !(bValid && (m_wait >= LIM));
    endfunction

    function automatic logic exp_busy(input logic [4:0] r);
        return SB_EN && (r != 5'd0) && m_busy[r];
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_wait <= 0; m_busy <= '0; m_we <= 1'b0; m_wreg <= '0; m_wdata <= '0;
            m_last_a_x <= 1'b0; m_last_b_x <= 1'b0;
        end else begin
            logic ax, bx;
            ax = aValid && exp_a_ready();
            bx = bValid && exp_b_ready();
            m_last_a_x <= ax;
            m_last_b_x <= bx;
            if (bx || !bValid) m_wait <= 0;
            else if (m_wait < LIM) m_wait <= m_wait + 1;
            m_we <= 1'b0;
            if (ax && aReg != 5'd0) begin
                m_we <= 1'b1; m_wreg <= aReg; m_wdata <= aData;
            end else if (bx && bReg != 5'd0) begin
                m_we <= 1'b1; m_wreg <= bReg; m_wdata <= bData;
            end
            if (bx) m_busy[bReg] <= 1'b0;
            if (issueValid && issueReg != 5'd0) m_busy[issueReg] <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard compare, every cycle out of reset
    always @(negedge clk) begin
        if (reset) begin
            check("aReady", 32'(aReady), 32'(exp_a_ready()));
            check("bReady", 32'(bReady), 32'(exp_b_ready()));
            check("we", 32'(gprWriteEnabled), 32'(m_we));
            check("wreg", 32'(gprWriteRegister), 32'(m_wreg));
            check("wdata", gprWriteInput, m_wdata);
            check("qbusy1", 32'(queryBusy1), 32'(exp_busy(queryReg1)));
            check("qbusy2", 32'(queryBusy2), 32'(exp_busy(queryReg2)));
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        aValid = 0; bValid = 0; issueValid = 0;
        aReg = 0; bReg = 0; issueReg = 0; aData = 0; bData = 0;
        queryReg1 = 0; queryReg2 = 0;
    endtask

    task automatic random_cycle();
        if (!aValid || m_last_a_x) begin
            aValid = 1'($urandom_range(0, 1));
            aReg   = 5'($urandom_range(0, 31));
            aData  = $urandom;
        end
        if (!bValid || m_last_b_x) begin
            bValid = ($urandom_range(0, 2) != 0);
            bReg   = 5'($urandom_range(0, 31));
            bData  = $urandom;
        end
        issueValid = ($urandom_range(0, 3) == 0);
        issueReg   = 5'($urandom_range(0, 31));
        queryReg1  = 5'($urandom_range(0, 31));
        queryReg2  = 5'($urandom_range(0, 31));
    endtask

    initial begin
        int low;
        reset = 0;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_we", 32'(gprWriteEnabled), 32'd0);
        check("rst_wreg", 32'(gprWriteRegister), 32'd0);
        check("rst_wdata", gprWriteInput, 32'd0);
        check("rst_bready", 32'(bReady), 32'd1);
        reset = 1;

        // A only
        step();
        aValid = 1; aReg = 5'd5; aData = 32'h1234_5678;
        step();
        aValid = 0;
        @(negedge clk);
        check("a_only_we", 32'(gprWriteEnabled), 32'd1);
        check("a_only_reg", 32'(gprWriteRegister), 32'd5);
        check("a_only_data", gprWriteInput, 32'h1234_5678);
        step();
        @(negedge clk);
        check("a_only_we_drop", 32'(gprWriteEnabled), 32'd0);
        check("a_only_hold", 32'(gprWriteRegister), 32'd5);

        // contention: B waits LIM cycles behind a continuous A stream
        step();
        aValid = 1; aReg = 5'd3; aData = 32'hAAAA_0003;
        bValid = 1; bReg = 5'd7; bData = 32'hBEEF_0007;
        low = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bReady) break;
            low++;
        end
        check("starve_low_cycles", 32'(low), 32'(LIM));
        check("starve_a_blocked", 32'(aReady), 32'd0);
        @(posedge clk); #1;
        aValid = 0; bValid = 0;
        @(negedge clk);
        check("starve_b_we", 32'(gprWriteEnabled), 32'd1);
        check("starve_b_reg", 32'(gprWriteRegister), 32'd7);
        check("starve_b_data", gprWriteInput, 32'hBEEF_0007);

        // write to r0
        step();
        aValid = 1; aReg = 5'd0; aData = 32'hFFFF_FFFF;
        @(negedge clk);
        check("r0_aready", 32'(aReady), 32'd1);
        step();
        aValid = 0;
        @(negedge clk);
        check("r0_we", 32'(gprWriteEnabled), 32'd0);
        check("r0_hold_reg", 32'(gprWriteRegister), 32'd7);
        check("r0_hold_data", gprWriteInput, 32'hBEEF_0007);

        // scoreboard
        step();
        issueValid = 1; issueReg = 5'd9; queryReg1 = 5'd9;
        @(negedge clk);
        check("sb_no_bypass", 32'(queryBusy1), 32'd0);
        step();
        issueValid = 0;
        @(negedge clk);
        check("sb_set", 32'(queryBusy1), 32'(SB_EN));
        bValid = 1; bReg = 5'd9; bData = 32'h0000_0009;
        step();
        bValid = 0;
        @(negedge clk);
        check("sb_clear", 32'(queryBusy1), 32'd0);
        issueValid = 1; issueReg = 5'd9;
        step();
        bValid = 1; bReg = 5'd9;
        step();
        issueValid = 0; bValid = 0;
        @(negedge clk);
        check("sb_set_wins", 32'(queryBusy1), 32'(SB_EN));

        // randomized traffic
        for (int c = 0; c < 2000; c++) begin
            step();
            random_cycle();
        end

        // reset mid-stream during a B transfer
        step();
        idle_inputs();
        issueValid = 1; issueReg = 5'd12; queryReg1 = 5'd12;
        step();
        issueValid = 0;
        bValid = 1; bReg = 5'd12; bData = 32'h1212_1212;
        @(negedge clk);
        #2 reset = 0;
        #1;
        check("mid_rst_we", 32'(gprWriteEnabled), 32'd0);
        check("mid_rst_reg", 32'(gprWriteRegister), 32'd0);
        check("mid_rst_data", gprWriteInput, 32'd0);
        check("mid_rst_busy", 32'(queryBusy1), 32'd0);
        step();
        bValid = 0;
        step();
        @(negedge clk);
        reset = 1;
        step();
        @(negedge clk);
        check("post_rst_we", 32'(gprWriteEnabled), 32'd0);
        check("post_rst_reg", 32'(gprWriteRegister), 32'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
